alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single registered ALU (1-cycle latency, op/in1/in2 in, out registered) between NREQ requesters, for example the execute stage and the address/branch unit.
- Arbitrates round-robin and drives the ALU operands.
- Tracks the in-flight operation and routes the result back to its owner with a valid/ready handshake.
- Holds a result the owner has not yet accepted, because the ALU output register updates every cycle.

Parameters:
- NREQ, 2, number of requesters (2..8).
- TW, 1, tag width; ceil(log2(NREQ)), minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle.
- req_op  in  4*NREQ  ALU opcode per requester (requester i at bits [4i+3:4i]).
- req_a  in  32*NREQ  operand 1 per requester.
- req_b  in  32*NREQ  operand 2 per requester.
- resp_valid  out  NREQ  result valid, one-hot to the owner.
- resp_ready  in  NREQ  owner accepts result.
- resp_data  out  32  result, shared bus.
- alu_op  out  4  to ALU op.
- alu_in1  out  32  to ALU in1.
- alu_in2  out  32  to ALU in2.
- alu_out  in  32  from ALU out (registered).

Behaviour:
- Reset (rst=0, async): rr_ptr=0, inflight=0, hold_full=0, resp_valid=0. Combinational outputs are then req_ready=0, alu_op=0000, alu_in1=0, alu_in2=0. The ALU's own sync reset is driven separately.
- Any result that is in flight or held is discarded on reset; no response is produced for it after reset deasserts.
- Arbitration:
  - Among asserted req_valid bits, the first index at or after rr_ptr (wrapping) wins.
  - On a fire (req_valid&req_ready), rr_ptr <= winner+1 mod NREQ.
  - rr_ptr is unchanged when nothing fires.
- Issue enable (combinational), issue_ok:
  - issue_ok = !hold_full && (!inflight || resp_ready[tag]).
  - Only the winner sees req_ready=1, and only when issue_ok.
  - req_ready may depend combinationally on resp_ready.
- ALU drive:
  - On a fire, alu_op/alu_in1/alu_in2 = the winner's fields in the same cycle T.
  - Otherwise they are zero (ADD 0+0).
- In-flight tracking:
  - On a fire in cycle T: inflight<=1, tag<=winner.
  - With no fire and the response accepted or held: inflight<=0.
- Response in cycle T+1:
  - resp_valid[tag]=1 and resp_data=alu_out, or hold_data if hold_full.
  - Throughput is one op per cycle when the owner holds resp_ready high.
- Backpressure:
  - If inflight and resp_ready[tag]=0, then hold_data<=alu_out, hold_full<=1, hold_tag<=tag.
  - resp_valid stays high and resp_data stays stable until accepted.
  - No issue occurs while hold_full.
  - On acceptance, hold_full<=0; a new issue is allowed in the following cycle.
- Simultaneous cases:
  - Accept and new fire in the same cycle: the next response is the new op in T+1 with no bubble.
  - Response owner and a new requester are the same index: legal, ordering is preserved.
- At most one response is outstanding. resp_valid is never multi-hot.
- Opcodes are passed unmodified. Undefined codes yield 0 from the ALU.

Optional Feature:
- Macro ALU_ARBITER_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output resp_err (1 bit), valid with resp_valid.
  - Legal opcodes: 0000, 1000, 0001, 0010, 0011, 0100, 0101, 1101, 0110, 0111. Any other opcode is still granted (consumes a slot) but alu_op is driven 0000 with zero operands.
  - The response carries resp_data=0 and resp_err=1. resp_err is held with hold_data under backpressure.
  - resp_err resets to 0.
- Undefined: no resp_err port; all opcodes are forwarded unmodified.

Decomposition:
- Shared package alu_pkg holds:
  - The 4-bit opcode constants (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
  - An op_legal function.
  - Widths XLEN=32 and OPW=4.
- The alu module is updated to use alu_pkg.
- One sub-module: rr_pick, a combinational round-robin priority picker (inputs req vector and ptr; outputs one-hot grant and index).

Test Plan:
- Single requester 0: ADD a=5, b=7, resp_ready=1 -> req_ready[0]=1 in T; resp_valid=01 and resp_data=12 in T+1; alu_op=0000 in all other cycles.
- Both requesters valid for 4 cycles: r0 SUB 10-3, r1 SLT -1<1, resp_ready=11 -> grants alternate 0,1,0,1; responses 7, 1, 7, 1 on consecutive cycles with no bubbles.
- r0 SRA 0x80000000>>>4 with resp_ready[0]=0 for 3 cycles -> resp_data=0xF8000000 stable; req_ready=00 while held; r1's queued op issues the cycle after acceptance.
- Reset asserted the cycle after a fire -> resp_valid=0 immediately. After release, no stale response; rr_ptr=0, so r0 wins a simultaneous request.
- NREQ=4, requesters 1 and 3 valid, rr_ptr=2 -> 3 granted first, then 1 (wrap).
- ALU_ARBITER_ILLEGAL_TRAP_EN defined, op=1111 -> alu_op=0000, resp_data=0, resp_err=1. Without the macro: alu_op=1111, resp_data=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode encodings, datapath widths and opcode legality check
package alu_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } alu_op_e;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle registered ALU with synchronous active-low reset
// Undefined opcodes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [OPW-1:0]  i_op,
  input  logic [XLEN-1:0] i_in1,
  input  logic [XLEN-1:0] i_in2,
  output logic [XLEN-1:0] o_out
);

  logic [XLEN-1:0] w_res;
  logic [4:0]      w_shamt;

  always_comb begin
    w_res   = '0;
    w_shamt = i_in2[4:0];
    case (i_op)
      OP_ADD:  w_res = i_in1 + i_in2;
      OP_SUB:  w_res = i_in1 - i_in2;
      OP_SLL:  w_res = i_in1 << w_shamt;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(i_in1) < $signed(i_in2)};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, i_in1 < i_in2};
      OP_XOR:  w_res = i_in1 ^ i_in2;
      OP_SRL:  w_res = i_in1 >> w_shamt;
      OP_SRA:  w_res = $signed(i_in1) >>> w_shamt;
      OP_OR:   w_res = i_in1 | i_in2;
      OP_AND:  w_res = i_in1 & i_in2;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_out <= '0;
    else          o_out <= w_res;
  end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational round-robin picker
// Grants the first asserted request at or after i_ptr, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int TW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [TW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [TW-1:0]   o_idx,
  output logic            o_any
);

  int              w_sum;
  logic [TW-1:0]   w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = int'(i_ptr) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_cand = TW'(w_sum);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one registered ALU among NREQ requesters
// Optional ALU_ARBITER_ILLEGAL_TRAP_EN: squash illegal opcodes and flag them on resp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OPW*NREQ-1:0]  req_op,
  input  logic [XLEN*NREQ-1:0] req_a,
  input  logic [XLEN*NREQ-1:0] req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic [OPW-1:0]       alu_op,
  output logic [XLEN-1:0]      alu_in1,
  output logic [XLEN-1:0]      alu_in2,
  input  logic [XLEN-1:0]      alu_out
`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
  ,
  output logic                 resp_err
`endif
);

  logic [TW-1:0]   r_rr_ptr;
  logic            r_inflight;
  logic [TW-1:0]   r_tag;
  logic            r_hold_full;
  logic [XLEN-1:0] r_hold_data;
  logic [TW-1:0]   r_hold_tag;

  logic [NREQ-1:0] w_grant;
  logic [TW-1:0]   w_win;
  logic            w_any;
  logic            w_issue_ok;
  logic            w_fire;
  logic            w_win_legal;
  logic [OPW-1:0]  w_win_op;
  logic [XLEN-1:0] w_win_a;
  logic [XLEN-1:0] w_win_b;
  logic [TW-1:0]   w_next_ptr;

  rr_pick #(.NREQ(NREQ), .TW(TW)) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  assign w_win_op = req_op[OPW*w_win +: OPW];
  assign w_win_a  = req_a[XLEN*w_win +: XLEN];
  assign w_win_b  = req_b[XLEN*w_win +: XLEN];

`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
  assign w_win_legal = op_legal(w_win_op);
`else
  assign w_win_legal = 1'b1;
`endif

  // A pending response blocks issue unless its owner drains it this very cycle.
  assign w_issue_ok = !r_hold_full && (!r_inflight || resp_ready[r_tag]);
  assign w_fire     = rst && w_any && w_issue_ok;
  assign w_next_ptr = (int'(w_win) == NREQ - 1) ? '0 : w_win + TW'(1);

  always_comb begin
    req_ready = '0;
    alu_op    = '0;
    alu_in1   = '0;
    alu_in2   = '0;
    if (w_fire) begin
      req_ready = w_grant;
      if (w_win_legal) begin
        alu_op  = w_win_op;
        alu_in1 = w_win_a;
        alu_in2 = w_win_b;
      end
    end
  end

  // inflight and hold_full are mutually exclusive: a held result blocks issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_inflight  <= 1'b0;
      r_tag       <= '0;
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_hold_tag  <= '0;
    end else begin
      r_inflight <= w_fire;
      if (w_fire) begin
        r_rr_ptr <= w_next_ptr;
        r_tag    <= w_win;
      end
      if (r_inflight && !resp_ready[r_tag]) begin
        r_hold_full <= 1'b1;
        r_hold_data <= alu_out;
        r_hold_tag  <= r_tag;
      end else if (r_hold_full && resp_ready[r_hold_tag]) begin
        r_hold_full <= 1'b0;
      end
    end
  end

`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
  logic r_err;
  logic r_hold_err;
  logic w_resp_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err      <= 1'b0;
      r_hold_err <= 1'b0;
    end else begin
      if (w_fire) r_err <= !w_win_legal;
      if (r_inflight && !resp_ready[r_tag]) r_hold_err <= r_err;
    end
  end

  assign w_resp_err = r_inflight ? r_err : (r_hold_full && r_hold_err);
  assign resp_err   = w_resp_err;
`endif

  always_comb begin
    resp_valid = '0;
    if (r_inflight)       resp_valid[r_tag]      = 1'b1;
    else if (r_hold_full) resp_valid[r_hold_tag] = 1'b1;
    resp_data = r_hold_full ? r_hold_data : alu_out;
`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
    if (w_resp_err) resp_data = '0;
`endif
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with real ALUs
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] resp_data, alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;

  logic [3:0]   req_valid4, req_ready4, resp_valid4, resp_ready4;
  logic [15:0]  req_op4;
  logic [127:0] req_a4, req_b4;
  logic [31:0]  resp_data4, alu_in1_4, alu_in2_4, alu_out4;
  logic [3:0]   alu_op4;

`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
  logic resp_err, resp_err4;
`endif

  alu_arbiter #(.NREQ(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
    , .resp_err(resp_err)
`endif
  );

  alu u_alu (.i_clk(clk), .i_rst_n(rst), .i_op(alu_op), .i_in1(alu_in1), .i_in2(alu_in2), .o_out(alu_out));

  alu_arbiter #(.NREQ(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .req_op(req_op4), .req_a(req_a4), .req_b(req_b4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp_data(resp_data4),
    .alu_op(alu_op4), .alu_in1(alu_in1_4), .alu_in2(alu_in2_4), .alu_out(alu_out4)
`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
    , .resp_err(resp_err4)
`endif
  );

  alu u_alu4 (.i_clk(clk), .i_rst_n(rst), .i_op(alu_op4), .i_in1(alu_in1_4), .i_in2(alu_in2_4), .o_out(alu_out4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    req_valid = '0; resp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    req_valid4 = '0; resp_ready4 = '0; req_op4 = '0; req_a4 = '0; req_b4 = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    zero_inputs();
    req_valid = 2'b11;
    set_req(0, 4'b0000, 32'd1, 32'd2);
    #2;
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_checks++;
    if (alu_op !== 4'b0000 || alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin
      n_fail++; $display("FAIL reset_alu_drive: got op=%b in1=%h in2=%h expected 0000/0/0", alu_op, alu_in1, alu_in2);
    end
    apply_reset();
    #2;
    n_checks++;
    if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got resp_valid=%b req_ready=%b expected 00/00", resp_valid, req_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    resp_ready = 2'b11;
    set_req(0, 4'b0000, 32'd5, 32'd7);
    req_valid = 2'b01;
    #2;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    n_checks++;
    if (alu_op !== 4'b0000 || alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin
      n_fail++; $display("FAIL single_drive: got op=%b in1=%0d in2=%0d expected 0000/5/7", alu_op, alu_in1, alu_in2);
    end
    tick();
    req_valid = 2'b00;
    #2;
    n_checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'd12) begin
      n_fail++; $display("FAIL single_resp: got valid=%b data=%0d expected 01/12", resp_valid, resp_data);
    end
    n_checks++;
    if (alu_op !== 4'b0000 || alu_in1 !== 32'd0) begin
      n_fail++; $display("FAIL single_idle_drive: got op=%b in1=%h expected 0000/0", alu_op, alu_in1);
    end
    tick();
    n_checks++;
    if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_drain: got %b expected 00", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_rdy, exp_rv;
    logic [31:0] exp_data;
    apply_reset();
    resp_ready = 2'b11;
    set_req(0, 4'b1000, 32'd10, 32'd3);
    set_req(1, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req_valid = 2'b00;
      #2;
      exp_rdy  = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      exp_rv   = (c >= 1 && c <= 4) ? ((c % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
      exp_data = (c % 2 == 1) ? 32'd7 : 32'd1;
      n_checks++;
      if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, req_ready, exp_rdy); end
      n_checks++;
      if (resp_valid !== exp_rv || (exp_rv != 2'b00 && resp_data !== exp_data)) begin
        n_fail++; $display("FAIL b2b_resp c%0d: got valid=%b data=%0d expected %b/%0d", c, resp_valid, resp_data, exp_rv, exp_data);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  rv_tab  [7] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [1:0]  rr_tab  [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    logic [1:0]  rdy_tab [7] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0]  vld_tab [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    logic [31:0] dat_tab [7] = '{32'd0, 32'hF800_0000, 32'hF800_0000, 32'hF800_0000, 32'hF800_0000, 32'd0, 32'd3};
    apply_reset();
    set_req(0, 4'b1101, 32'h8000_0000, 32'd4);
    set_req(1, 4'b0000, 32'd1, 32'd2);
    for (int c = 0; c < 7; c++) begin
      req_valid  = rv_tab[c];
      resp_ready = rr_tab[c];
      #2;
      n_checks++;
      if (req_ready !== rdy_tab[c]) begin n_fail++; $display("FAIL bp_ready c%0d: got %b expected %b", c, req_ready, rdy_tab[c]); end
      n_checks++;
      if (resp_valid !== vld_tab[c] || (vld_tab[c] != 2'b00 && resp_data !== dat_tab[c])) begin
        n_fail++; $display("FAIL bp_resp c%0d: got valid=%b data=%h expected %b/%h", c, resp_valid, resp_data, vld_tab[c], dat_tab[c]);
      end
      if (c == 5) begin
        n_checks++;
        if (alu_in1 !== 32'd1) begin n_fail++; $display("FAIL bp_issue_r1: got in1=%h expected 1", alu_in1); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    resp_ready = 2'b11;
    set_req(0, 4'b0000, 32'd5, 32'd7);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    rst = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL midflight_async: got %b expected 00", resp_valid); end
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_checks++;
      if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL midflight_stale c%0d: got %b expected 00", c, resp_valid); end
      tick();
    end
    set_req(1, 4'b0000, 32'd1, 32'd1);
    req_valid = 2'b11;
    #2;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midflight_ptr: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_rr_wrap4();
    apply_reset();
    resp_ready4 = 4'b1111;
    req_op4 = '0;
    req_a4[32*3 +: 32] = 32'd20;
    req_b4[32*3 +: 32] = 32'd22;
    req_valid4 = 4'b0010;
    #2;
    n_checks++;
    if (req_ready4 !== 4'b0010) begin n_fail++; $display("FAIL wrap4_prime: got %b expected 0010", req_ready4); end
    tick();
    req_valid4 = 4'b1010;
    #2;
    n_checks++;
    if (req_ready4 !== 4'b1000) begin n_fail++; $display("FAIL wrap4_first: got %b expected 1000", req_ready4); end
    tick();
    #2;
    n_checks++;
    if (req_ready4 !== 4'b0010) begin n_fail++; $display("FAIL wrap4_second: got %b expected 0010", req_ready4); end
    n_checks++;
    if (resp_valid4 !== 4'b1000 || resp_data4 !== 32'd42) begin
      n_fail++; $display("FAIL wrap4_resp: got valid=%b data=%0d expected 1000/42", resp_valid4, resp_data4);
    end
    tick();
    req_valid4 = 4'b0000;
    tick();
  endtask

  task automatic test_illegal();
    apply_reset();
    resp_ready = 2'b11;
    set_req(0, 4'b1111, 32'd5, 32'd6);
    req_valid = 2'b01;
    #2;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL illegal_grant: got %b expected 01", req_ready); end
`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
    n_checks++;
    if (alu_op !== 4'b0000 || alu_in1 !== 32'd0) begin
      n_fail++; $display("FAIL illegal_squash: got op=%b in1=%h expected 0000/0", alu_op, alu_in1);
    end
`else
    n_checks++;
    if (alu_op !== 4'b1111 || alu_in1 !== 32'd5) begin
      n_fail++; $display("FAIL illegal_forward: got op=%b in1=%h expected 1111/5", alu_op, alu_in1);
    end
`endif
    tick();
    set_req(0, 4'b0000, 32'd2, 32'd3);
    #2;
    n_checks++;
    if (resp_valid !== 2'b01 || resp_data !== 32'd0) begin
      n_fail++; $display("FAIL illegal_resp: got valid=%b data=%h expected 01/0", resp_valid, resp_data);
    end
`ifdef ALU_ARBITER_ILLEGAL_TRAP_EN
    n_checks++;
    if (resp_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err: got %b expected 1", resp_err); end
    tick();
    req_valid = 2'b00;
    #2;
    n_checks++;
    if (resp_err !== 1'b0 || resp_data !== 32'd5) begin
      n_fail++; $display("FAIL legal_after_err: got err=%b data=%0d expected 0/5", resp_err, resp_data);
    end
`endif
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    zero_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_rr_wrap4();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
